// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART with transmit and receive FIFOs.
// Registers: status at BASE_ADDRESS, RX data at +4, TX data at +8.

module io_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == FULL_COUNT);
  assign rdata     = mem_r[rd_ptr_r];
  // A pop on empty is ignored; a push on full only lands when a pop frees a slot
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

module io_uart #(
  parameter logic [31:0] BASE_ADDRESS = 32'h18,
  parameter int          BAUD_DIVIDE  = 50000000 / 115200,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int BW = $clog2(BAUD_DIVIDE + 1);
  localparam logic [BW-1:0] BIT_END  = BW'(BAUD_DIVIDE - 1);
  localparam logic [BW-1:0] HALF_END = BW'(BAUD_DIVIDE / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  logic          sel_status_s;
  logic          sel_rx_s;
  logic          tx_write_s;
  logic          unused_s;

  tx_state_t     tx_state_r;
  logic [BW-1:0] tx_cnt_r;
  logic [2:0]    tx_bit_r;
  logic [7:0]    tx_shift_r;
  logic          tx_pop_s;
  logic [7:0]    tx_head_s;
  logic          tx_empty_s;
  logic          tx_full_s;

  rx_state_t     rx_state_r;
  logic [BW-1:0] rx_cnt_r;
  logic [2:0]    rx_bit_r;
  logic [7:0]    rx_shift_r;
  logic          rx_meta_r;
  logic          rx_sync_r;
  logic          rx_prev_r;
  logic          rx_push_r;
  logic          frame_evt_r;
  logic          overrun_evt_s;
  logic [7:0]    rx_head_s;
  logic          rx_empty_s;
  logic          rx_full_s;
  logic          overrun_r;
  logic          frame_err_r;

  assign sel_status_s = io_read_en  && (io_address == BASE_ADDRESS);
  assign sel_rx_s     = io_read_en  && (io_address == BASE_ADDRESS + 32'd4);
  assign tx_write_s   = io_write_en && (io_address == BASE_ADDRESS + 32'd8);
  assign unused_s     = ^io_write_data[31:8];

  // The TX FSM takes a new byte when idle, or straight out of the stop bit for gapless frames
  assign tx_pop_s = ~tx_empty_s &
                    ((tx_state_r == TX_IDLE) || ((tx_state_r == TX_STOP) && (tx_cnt_r == BIT_END)));

  io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (tx_write_s),
    .pop    (tx_pop_s),
    .wdata  (io_write_data[7:0]),
    .rdata  (tx_head_s),
    .empty  (tx_empty_s),
    .full   (tx_full_s)
  );

  io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (rx_push_r),
    .pop    (sel_rx_s),
    .wdata  (rx_shift_r),
    .rdata  (rx_head_s),
    .empty  (rx_empty_s),
    .full   (rx_full_s)
  );

  // Transmit state machine with registered serial output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= {BW{1'b0}};
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      uart_tx    <= 1'b1;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          tx_cnt_r <= {BW{1'b0}};
          if (tx_pop_s) begin
            tx_shift_r <= tx_head_s;
            tx_state_r <= TX_START;
            uart_tx    <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt_r == BIT_END) begin
            tx_cnt_r   <= {BW{1'b0}};
            tx_bit_r   <= 3'd0;
            tx_state_r <= TX_DATA;
            uart_tx    <= tx_shift_r[0];
          end else begin
            tx_cnt_r <= tx_cnt_r + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_r == BIT_END) begin
            tx_cnt_r <= {BW{1'b0}};
            if (tx_bit_r == 3'd7) begin
              tx_state_r <= TX_STOP;
              uart_tx    <= 1'b1;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
              uart_tx    <= tx_shift_r[1];
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_r == BIT_END) begin
            tx_cnt_r <= {BW{1'b0}};
            if (tx_pop_s) begin
              tx_shift_r <= tx_head_s;
              tx_state_r <= TX_START;
              uart_tx    <= 1'b0;
            end else begin
              tx_state_r <= TX_IDLE;
              uart_tx    <= 1'b1;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 1'b1;
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          uart_tx    <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receive state machine; samples at mid-bit after the half-bit start check
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_r  <= RX_IDLE;
      rx_cnt_r    <= {BW{1'b0}};
      rx_bit_r    <= 3'd0;
      rx_shift_r  <= 8'd0;
      rx_push_r   <= 1'b0;
      frame_evt_r <= 1'b0;
    end else begin
      rx_push_r   <= 1'b0;
      frame_evt_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= {BW{1'b0}};
          if (rx_prev_r && !rx_sync_r) rx_state_r <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_r == HALF_END) begin
            rx_cnt_r <= {BW{1'b0}};
            rx_bit_r <= 3'd0;
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == BIT_END) begin
            rx_cnt_r   <= {BW{1'b0}};
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
            else                  rx_bit_r   <= rx_bit_r + 3'd1;
          end else begin
            rx_cnt_r <= rx_cnt_r + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == BIT_END) begin
            rx_cnt_r    <= {BW{1'b0}};
            rx_state_r  <= RX_IDLE;
            rx_push_r   <= rx_sync_r;
            frame_evt_r <= ~rx_sync_r;
          end else begin
            rx_cnt_r <= rx_cnt_r + 1'b1;
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  assign overrun_evt_s = rx_push_r & rx_full_s & ~sel_rx_s;

  // Sticky error flags; a new event beats a same-cycle status-read clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (overrun_evt_s)     overrun_r <= 1'b1;
      else if (sel_status_s) overrun_r <= 1'b0;
      if (frame_evt_r)       frame_err_r <= 1'b1;
      else if (sel_status_s) frame_err_r <= 1'b0;
    end
  end

  // Registered read data; unmatched accesses leave it untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_read_data <= 32'd0;
    end else if (sel_status_s) begin
      io_read_data <= {28'd0, frame_err_r, overrun_r, ~rx_empty_s, ~tx_full_s};
    end else if (sel_rx_s) begin
      io_read_data <= rx_empty_s ? 32'd0 : {24'd0, rx_head_s};
    end
  end
endmodule

// File: tb/tb_io_uart.sv
// Directed and randomized bench for io_uart against a queue-based model.
module tb_io_uart;
  localparam int          BAUD   = 16;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] BASE   = 32'h18;
  localparam logic [31:0] A_STAT = BASE;
  localparam logic [31:0] A_RX   = BASE + 32'd4;
  localparam logic [31:0] A_TX   = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        uart_tx;
  logic        uart_rx;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_model[$];
  logic       m_over  = 1'b0;
  logic       m_frame = 1'b0;

  always #5 clk = ~clk;

  io_uart #(.BASE_ADDRESS(BASE), .BAUD_DIVIDE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .io_write_en  (io_write_en),
    .io_read_en   (io_read_en),
    .io_address   (io_address),
    .io_write_data(io_write_data),
    .io_read_data (io_read_data),
    .uart_tx      (uart_tx),
    .uart_rx      (uart_rx)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic io_wr(input logic [31:0] a, input logic [31:0] d);
    io_address = a; io_write_data = d; io_write_en = 1'b1;
    cyc(1);
    io_write_en = 1'b0;
  endtask

  task automatic io_rd(input logic [31:0] a, output logic [31:0] d);
    io_address = a; io_read_en = 1'b1;
    cyc(1);
    io_read_en = 1'b0;
    d = io_read_data;
  endtask

  // Status read: bit0 is given by the caller, the rest comes from the model
  task automatic rd_stat(input string tag, input logic txnf);
    logic [31:0] d;
    logic [31:0] e;
    e = {28'd0, m_frame, m_over, (rx_model.size() != 0), txnf};
    io_rd(A_STAT, d);
    check(tag, d, e);
    m_over = 1'b0;
    m_frame = 1'b0;
  endtask

  task automatic rd_rx(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = 32'd0;
    if (rx_model.size() != 0) e = {24'd0, rx_model.pop_front()};
    io_rd(A_RX, d);
    check(tag, d, e);
  endtask

  // Called at the first cycle (k0) of a frame to be observed; returns one cycle past its end
  task automatic tx_frame(input logic [7:0] b, input int k0, input string tag);
    int   i;
    logic e;
    for (int k = k0; k < 10 * BAUD; k++) begin
      i = k / BAUD;
      if (i == 0)      e = 1'b0;
      else if (i == 9) e = 1'b1;
      else             e = b[i-1];
      check(tag, {31'd0, uart_tx}, {31'd0, e});
      cyc(1);
    end
  endtask

  task automatic tx_idle(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      check(tag, {31'd0, uart_tx}, 32'd1);
      cyc(1);
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      cyc(BAUD);
    end
    uart_rx = 1'b1;
    if (!stop)                     m_frame = 1'b1;
    else if (rx_model.size() < DEPTH) rx_model.push_back(b);
    else                           m_over = 1'b1;
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] d;
    reset_n = 1'b0; io_write_en = 1'b0; io_read_en = 1'b0;
    io_address = 32'd0; io_write_data = 32'd0; uart_rx = 1'b1;
    cyc(3);
    check("reset_tx", {31'd0, uart_tx}, 32'd1);
    check("reset_rdata", io_read_data, 32'd0);
    reset_n = 1'b1;
    cyc(2);
    rd_stat("reset_status", 1'b1);

    // Single byte: start bit exactly two cycles after the strobe
    io_wr(A_TX, 32'h55);
    check("tx_pre_start", {31'd0, uart_tx}, 32'd1);
    cyc(1);
    tx_frame(8'h55, 0, "tx_55");
    tx_idle(2 * BAUD, "tx_idle_55");

    for (int n = 0; n < 3; n++) begin
      b = 8'($urandom);
      io_wr(A_TX, {24'd0, b});
      cyc(1);
      tx_frame(b, 0, "tx_rand");
      tx_idle(3, "tx_idle_rand");
    end

    // Burst of 10 with the first already in the shifter: 9 gapless frames, 10th dropped
    io_wr(A_TX, 32'h00);
    cyc(1);
    for (int j = 1; j < 10; j++) io_wr(A_TX, j);
    rd_stat("tx_full_status", 1'b0);
    tx_frame(8'h00, 10, "b2b_frame0");
    for (int j = 1; j < 9; j++) tx_frame(8'(j), 0, "b2b_frame");
    tx_idle(2 * BAUD, "b2b_drop");
    rd_stat("tx_drained_status", 1'b1);

    rx_send(8'hA3, 1'b1);
    cyc(2);
    rd_stat("rx_a3_status", 1'b1);
    rd_rx("rx_a3_data");
    io_rd(A_TX, d);
    check("read_tx_addr_holds", d, 32'hA3);
    io_wr(A_STAT, 32'hFF);
    rd_stat("rx_after_read_status", 1'b1);

    for (int n = 0; n < 3; n++) rx_send(8'($urandom), 1'b1);
    cyc(2);
    rd_stat("rx_rand_status", 1'b1);
    for (int n = 0; n < 3; n++) rd_rx("rx_rand_data");

    uart_rx = 1'b0;
    cyc(BAUD / 2 - 3);
    uart_rx = 1'b1;
    cyc(12 * BAUD);
    rd_stat("glitch_status", 1'b1);

    rx_send(8'($urandom), 1'b0);
    cyc(2);
    rd_stat("frame_err_status", 1'b1);
    rd_stat("frame_err_cleared", 1'b1);

    for (int n = 0; n < DEPTH + 1; n++) rx_send(8'($urandom), 1'b1);
    cyc(2);
    rd_stat("overrun_status", 1'b1);
    for (int n = 0; n < DEPTH; n++) rd_rx("overrun_data");
    rd_rx("overrun_empty_read");
    rd_stat("overrun_cleared", 1'b1);

    // Reset in the middle of data bit 0 of a zero byte, with bytes queued on both sides
    rx_send(8'h5A, 1'b1);
    cyc(2);
    rd_stat("pre_reset_status", 1'b1);
    io_wr(A_TX, 32'h00);
    io_wr(A_TX, 32'h11);
    io_wr(A_TX, 32'h22);
    cyc(BAUD + BAUD / 2 - 1);
    check("pre_reset_tx_low", {31'd0, uart_tx}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("async_reset_tx", {31'd0, uart_tx}, 32'd1);
    check("async_reset_rdata", io_read_data, 32'd0);
    cyc(2);
    reset_n = 1'b1;
    rx_model.delete();
    cyc(2);
    tx_idle(11 * BAUD, "post_reset_idle");
    rd_stat("post_reset_status", 1'b1);
    rd_rx("post_reset_rx_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
